// File: rtl/ball_motion_engine_if.sv
// Signal bundle between the ball motion engine and its surroundings:
// detector results and game controls in, ball state and score out.
interface ball_motion_engine_if;
    // Inputs are sampled on every clk edge. frame_tick qualifies all motion.
    // There is no back-pressure: every output is a registered level, except
    // point_pulse, which is a one-clk strobe.
    logic        frame_tick;
    logic        serve;
    logic        restart;
    logic        collide;
    logic [1:0]  edg;
    logic [21:0] ball_location;
    logic [31:0] ball_velocity;
    logic [3:0]  score_p0;
    logic [3:0]  score_p1;
    logic [5:0]  rally_cnt;
    logic        point_pulse;
    logic        server;
    logic        game_over;
    logic [2:0]  state_dbg;

    modport master (
        input  frame_tick, serve, restart, collide, edg,
        output ball_location, ball_velocity, score_p0, score_p1, rally_cnt,
               point_pulse, server, game_over, state_dbg
    );

    modport slave (
        output frame_tick, serve, restart, collide, edg,
        input  ball_location, ball_velocity, score_p0, score_p1, rally_cnt,
               point_pulse, server, game_over, state_dbg
    );
endinterface

// File: rtl/ball_motion_engine.sv
// Ball state owner for the pingpong game: per-frame position integration,
// paddle reflection, point scoring and the serve/rally/point/game-over sequence.
module ball_motion_engine #(
    parameter int A_MAX      = 790,
    parameter int B_MAX      = 1280,
    parameter int SERVE_B    = 100,
    parameter int SERVE_VA   = 2,
    parameter int SERVE_VB   = 8,
    parameter int HIT_SPEED  = 10,
    parameter int HIT_LOCK   = 8,
    parameter int POINT_HOLD = 60,
    parameter int WIN_SCORE  = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ball_motion_engine_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_FLY, S_LOCK, S_POINT, S_OVER} state_t;

    localparam logic [10:0]        SERVE_A   = 11'(A_MAX / 2);
    localparam logic [10:0]        SERVE_B0  = 11'(SERVE_B);
    localparam logic [10:0]        SERVE_B1  = 11'(B_MAX - SERVE_B);
    localparam logic signed [16:0] A_LIM     = 17'(A_MAX + 1);
    localparam logic signed [16:0] B_LIM     = 17'(B_MAX + 1);
    localparam logic [15:0]        VA_SERVE  = 16'(SERVE_VA);
    localparam logic [15:0]        VB_POS    = 16'(SERVE_VB);
    localparam logic [15:0]        VB_NEG    = 16'(-SERVE_VB);
    localparam logic [15:0]        HIT_BASE  = 16'(HIT_SPEED);
    localparam logic [7:0]         LOCK_LOAD = 8'(HIT_LOCK);
    localparam logic [7:0]         HOLD_LOAD = 8'(POINT_HOLD);
    localparam logic [3:0]         WIN       = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic [10:0] loc_a_q, loc_a_d, loc_b_q, loc_b_d;
    logic [15:0] va_q, va_d, vb_q, vb_d;
    logic [3:0]  score0_q, score0_d, score1_q, score1_d;
    logic [5:0]  rally_q, rally_d;
    logic [7:0]  lock_q, lock_d, hold_q, hold_d;
    logic        pulse_q, pulse_d;
    logic        server_q, server_d;
    logic        over_q, over_d;
    logic [15:0] hit_mag;
    logic [15:0] vb_new;

    // Saturate instead of wrapping so an exit always lands beyond the
    // detector's edge thresholds.
    function automatic logic [10:0] sat_step(input logic [10:0] pos,
                                             input logic [15:0] vel,
                                             input logic signed [16:0] lim);
        logic signed [16:0] sum;
        sum = $signed({6'b0, pos}) + $signed({vel[15], vel});
        if (sum < 0)        return '0;
        else if (sum > lim) return lim[10:0];
        else                return sum[10:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        loc_a_d  = loc_a_q;
        loc_b_d  = loc_b_q;
        va_d     = va_q;
        vb_d     = vb_q;
        score0_d = score0_q;
        score1_d = score1_q;
        rally_d  = rally_q;
        lock_d   = lock_q;
        hold_d   = hold_q;
        pulse_d  = 1'b0;
        server_d = server_q;
        hit_mag  = HIT_BASE + {12'b0, rally_q[5:2]};
        vb_new   = vb_q;

        if (bus.restart) begin
            state_d  = S_IDLE;
            loc_a_d  = SERVE_A;
            loc_b_d  = SERVE_B0;
            va_d     = '0;
            vb_d     = '0;
            score0_d = '0;
            score1_d = '0;
            rally_d  = '0;
            lock_d   = '0;
            hold_d   = '0;
            server_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    loc_a_d = SERVE_A;
                    loc_b_d = server_q ? SERVE_B1 : SERVE_B0;
                    va_d    = '0;
                    vb_d    = '0;
                    if (bus.serve) begin
                        va_d    = VA_SERVE;
                        vb_d    = server_q ? VB_NEG : VB_POS;
                        rally_d = '0;
                        state_d = S_FLY;
                    end
                end
                S_FLY, S_LOCK: begin
                    if (bus.frame_tick) begin
                        if (bus.edg == 2'b01 || bus.edg == 2'b10) begin
                            // The conceding player serves next.
                            if (bus.edg == 2'b01) begin
                                if (score0_q != WIN) score0_d = score0_q + 4'd1;
                                server_d = 1'b1;
                            end else begin
                                if (score1_q != WIN) score1_d = score1_q + 4'd1;
                                server_d = 1'b0;
                            end
                            va_d    = '0;
                            vb_d    = '0;
                            pulse_d = 1'b1;
                            lock_d  = '0;
                            hold_d  = HOLD_LOAD;
                            state_d = S_POINT;
                        end else begin
                            if (state_q == S_FLY && bus.collide) begin
                                vb_new = vb_q[15] ? hit_mag : -hit_mag;
                                if (rally_q != 6'd63) rally_d = rally_q + 6'd1;
                                lock_d  = LOCK_LOAD;
                                state_d = S_LOCK;
                            end else if (state_q == S_LOCK) begin
                                lock_d = lock_q - 8'd1;
                                if (lock_q <= 8'd1) state_d = S_FLY;
                            end
                            vb_d    = vb_new;
                            loc_a_d = sat_step(loc_a_q, va_q, A_LIM);
                            loc_b_d = sat_step(loc_b_q, vb_new, B_LIM);
                        end
                    end
                end
                S_POINT: begin
                    if (bus.frame_tick) begin
                        hold_d = hold_q - 8'd1;
                        if (hold_q <= 8'd1) begin
                            hold_d = '0;
                            if (score0_q == WIN || score1_q == WIN) begin
                                state_d = S_OVER;
                            end else begin
                                state_d = S_IDLE;
                                loc_a_d = SERVE_A;
                                loc_b_d = server_q ? SERVE_B1 : SERVE_B0;
                            end
                        end
                    end
                end
                S_OVER: ;
                default: state_d = S_IDLE;
            endcase
        end
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            loc_a_q  <= SERVE_A;
            loc_b_q  <= SERVE_B0;
            va_q     <= '0;
            vb_q     <= '0;
            score0_q <= '0;
            score1_q <= '0;
            rally_q  <= '0;
            lock_q   <= '0;
            hold_q   <= '0;
            pulse_q  <= 1'b0;
            server_q <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            loc_a_q  <= loc_a_d;
            loc_b_q  <= loc_b_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            rally_q  <= rally_d;
            lock_q   <= lock_d;
            hold_q   <= hold_d;
            pulse_q  <= pulse_d;
            server_q <= server_d;
            over_q   <= over_d;
        end
    end

    assign bus.ball_location = {loc_a_q, loc_b_q};
    assign bus.ball_velocity = {va_q, vb_q};
    assign bus.score_p0      = score0_q;
    assign bus.score_p1      = score1_q;
    assign bus.rally_cnt     = rally_q;
    assign bus.point_pulse   = pulse_q;
    assign bus.server        = server_q;
    assign bus.game_over     = over_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: serve, flight, paddle hits, points,
// simultaneous edge/collide, game over, restart and asynchronous reset.
module tb_ball_motion_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLY   = 3'd1;
    localparam logic [2:0] ST_LOCK  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    ball_motion_engine_if bus();

    ball_motion_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1);
    end

    // Tasks start and end just after a falling edge.
    task automatic tick(input logic c, input logic [1:0] e);
        bus.frame_tick = 1'b1;
        bus.collide    = c;
        bus.edg        = e;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.collide    = 1'b0;
        bus.edg        = 2'b00;
    endtask

    task automatic ticks(input int n, input logic c);
        repeat (n) begin
            tick(c, 2'b00);
            @(negedge clk);
        end
    endtask

    task automatic pulse_serve();
        bus.serve = 1'b1;
        @(negedge clk);
        bus.serve = 1'b0;
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
    endtask

    task automatic test_reset();
        bus.frame_tick = 1'b0; bus.serve = 1'b0; bus.restart = 1'b0;
        bus.collide = 1'b0; bus.edg = 2'b00;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (bus.ball_location !== {11'd395, 11'd100})
            $display("FAIL reset_loc: got %h want %h", bus.ball_location, {11'd395, 11'd100});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.ball_velocity, bus.score_p0, bus.score_p1, bus.rally_cnt, bus.point_pulse,
             bus.server, bus.game_over, bus.state_dbg} !== 53'd0)
            $display("FAIL reset_state: got vel %h sc %0d/%0d rally %0d pulse %b srv %b over %b st %0d want all 0",
                     bus.ball_velocity, bus.score_p0, bus.score_p1, bus.rally_cnt,
                     bus.point_pulse, bus.server, bus.game_over, bus.state_dbg);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_serve_fly();
        pulse_serve();
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_velocity, bus.ball_location} !== {ST_FLY, 16'd2, 16'd8, 11'd395, 11'd100})
            $display("FAIL serve_start: got st %0d vel %h loc %h want st 1 vel 00020008 loc held",
                     bus.state_dbg, bus.ball_velocity, bus.ball_location);
        else pass_cnt++;
        ticks(2, 1'b0);
        tick(1'b0, 2'b11);
        @(negedge clk);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_location} !== {ST_FLY, 11'd401, 11'd124})
            $display("FAIL fly_3_ticks: got st %0d loc %h want st 1 loc %h",
                     bus.state_dbg, bus.ball_location, {11'd401, 11'd124});
        else pass_cnt++;
        pulse_serve();
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_velocity, bus.rally_cnt} !== {ST_FLY, 16'd2, 16'd8, 6'd0})
            $display("FAIL serve_in_fly: got st %0d vel %h rally %0d want unchanged",
                     bus.state_dbg, bus.ball_velocity, bus.rally_cnt);
        else pass_cnt++;
    endtask

    task automatic test_paddle_hit();
        logic [15:0] exp_vb [4];
        exp_vb[0] = 16'd10; exp_vb[1] = 16'hFFF6; exp_vb[2] = 16'd10; exp_vb[3] = 16'hFFF5;
        tick(1'b1, 2'b00);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_velocity, bus.rally_cnt, bus.ball_location} !==
            {ST_LOCK, 16'd2, 16'hFFF6, 6'd1, 11'd403, 11'd114})
            $display("FAIL first_hit: got st %0d vel %h rally %0d loc %h want st 2 vel 0002fff6 rally 1 loc %h",
                     bus.state_dbg, bus.ball_velocity, bus.rally_cnt, bus.ball_location, {11'd403, 11'd114});
        else pass_cnt++;
        @(negedge clk);
        ticks(8, 1'b1);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_velocity[15:0], bus.rally_cnt, bus.ball_location} !==
            {ST_FLY, 16'hFFF6, 6'd1, 11'd419, 11'd34})
            $display("FAIL lock_ignores_collide: got st %0d vb %h rally %0d loc %h want st 1 vb fff6 rally 1 loc %h",
                     bus.state_dbg, bus.ball_velocity[15:0], bus.rally_cnt, bus.ball_location, {11'd419, 11'd34});
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 2'b00);
            chk_cnt++;
            if ({bus.ball_velocity[15:0], bus.rally_cnt} !== {exp_vb[i], 6'(i + 2)})
                $display("FAIL hit_%0d: got vb %h rally %0d want vb %h rally %0d",
                         i + 2, bus.ball_velocity[15:0], bus.rally_cnt, exp_vb[i], i + 2);
            else pass_cnt++;
            @(negedge clk);
            if (i < 3) ticks(8, 1'b0);
        end
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_location} !== {ST_LOCK, 11'd475, 11'd113})
            $display("FAIL after_hits_loc: got st %0d loc %h want st 2 loc %h",
                     bus.state_dbg, bus.ball_location, {11'd475, 11'd113});
        else pass_cnt++;
    endtask

    task automatic test_edge_point();
        pulse_restart();
        chk_cnt++;
        if ({bus.state_dbg, bus.rally_cnt, bus.ball_velocity, bus.ball_location} !==
            {ST_IDLE, 6'd0, 32'd0, 11'd395, 11'd100})
            $display("FAIL restart_mid_rally: got st %0d rally %0d vel %h loc %h want idle zeros serve pos",
                     bus.state_dbg, bus.rally_cnt, bus.ball_velocity, bus.ball_location);
        else pass_cnt++;
        pulse_serve();
        ticks(147, 1'b0);
        tick(1'b0, 2'b00);
        chk_cnt++;
        if (bus.ball_location !== {11'd691, 11'd1281})
            $display("FAIL b_saturate: got loc %h want %h", bus.ball_location, {11'd691, 11'd1281});
        else pass_cnt++;
        @(negedge clk);
        tick(1'b0, 2'b01);
        chk_cnt++;
        if ({bus.state_dbg, bus.score_p0, bus.score_p1, bus.point_pulse, bus.ball_velocity,
             bus.server, bus.ball_location} !== {ST_POINT, 4'd1, 4'd0, 1'b1, 32'd0, 1'b1, 11'd691, 11'd1281})
            $display("FAIL point_p0: got st %0d sc %0d/%0d pulse %b vel %h srv %b loc %h",
                     bus.state_dbg, bus.score_p0, bus.score_p1, bus.point_pulse,
                     bus.ball_velocity, bus.server, bus.ball_location);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.point_pulse !== 1'b0)
            $display("FAIL pulse_width: got %b want 0", bus.point_pulse);
        else pass_cnt++;
        ticks(59, 1'b0);
        chk_cnt++;
        if (bus.state_dbg !== ST_POINT)
            $display("FAIL hold_59: got st %0d want %0d", bus.state_dbg, ST_POINT);
        else pass_cnt++;
        ticks(1, 1'b0);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_location} !== {ST_IDLE, 11'd395, 11'd1180})
            $display("FAIL hold_done_p1_serve: got st %0d loc %h want st 0 loc %h",
                     bus.state_dbg, bus.ball_location, {11'd395, 11'd1180});
        else pass_cnt++;
    endtask

    task automatic test_edge_and_collide();
        pulse_serve();
        chk_cnt++;
        if (bus.ball_velocity !== {16'd2, 16'hFFF8})
            $display("FAIL p1_serve_vel: got %h want 0002fff8", bus.ball_velocity);
        else pass_cnt++;
        tick(1'b1, 2'b00);
        @(negedge clk);
        ticks(8, 1'b0);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_velocity[15:0], bus.rally_cnt, bus.ball_location} !==
            {ST_FLY, 16'd10, 6'd1, 11'd413, 11'd1270})
            $display("FAIL p1_hit_flight: got st %0d vb %h rally %0d loc %h want st 1 vb 000a rally 1 loc %h",
                     bus.state_dbg, bus.ball_velocity[15:0], bus.rally_cnt, bus.ball_location, {11'd413, 11'd1270});
        else pass_cnt++;
        tick(1'b1, 2'b10);
        chk_cnt++;
        if ({bus.state_dbg, bus.score_p0, bus.score_p1, bus.ball_velocity, bus.rally_cnt,
             bus.server, bus.point_pulse, bus.ball_location} !==
            {ST_POINT, 4'd1, 4'd1, 32'd0, 6'd1, 1'b0, 1'b1, 11'd413, 11'd1270})
            $display("FAIL edge_beats_collide: got st %0d sc %0d/%0d vel %h rally %0d srv %b pulse %b loc %h",
                     bus.state_dbg, bus.score_p0, bus.score_p1, bus.ball_velocity,
                     bus.rally_cnt, bus.server, bus.point_pulse, bus.ball_location);
        else pass_cnt++;
        @(negedge clk);
        ticks(60, 1'b0);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_location} !== {ST_IDLE, 11'd395, 11'd100})
            $display("FAIL p0_serve_pos: got st %0d loc %h want st 0 loc %h",
                     bus.state_dbg, bus.ball_location, {11'd395, 11'd100});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        pulse_serve();
        ticks(2, 1'b0);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_location} !== {ST_FLY, 11'd399, 11'd116})
            $display("FAIL pre_reset_fly: got st %0d loc %h want st 1 loc %h",
                     bus.state_dbg, bus.ball_location, {11'd399, 11'd116});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_location, bus.ball_velocity, bus.score_p0, bus.score_p1,
             bus.server, bus.game_over} !== {ST_IDLE, 11'd395, 11'd100, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0})
            $display("FAIL async_reset: got st %0d loc %h vel %h sc %0d/%0d srv %b over %b want reset values",
                     bus.state_dbg, bus.ball_location, bus.ball_velocity,
                     bus.score_p0, bus.score_p1, bus.server, bus.game_over);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 10; i++) begin
            pulse_serve();
            tick(1'b0, 2'b10);
            @(negedge clk);
            ticks(60, 1'b0);
        end
        chk_cnt++;
        if ({bus.state_dbg, bus.score_p0, bus.score_p1, bus.server} !== {ST_IDLE, 4'd0, 4'd10, 1'b0})
            $display("FAIL ten_points: got st %0d sc %0d/%0d srv %b want st 0 sc 0/10 srv 0",
                     bus.state_dbg, bus.score_p0, bus.score_p1, bus.server);
        else pass_cnt++;
        pulse_serve();
        tick(1'b0, 2'b10);
        @(negedge clk);
        ticks(59, 1'b0);
        chk_cnt++;
        if ({bus.state_dbg, bus.score_p1, bus.game_over} !== {ST_POINT, 4'd11, 1'b0})
            $display("FAIL win_hold: got st %0d sc1 %0d over %b want st 3 sc1 11 over 0",
                     bus.state_dbg, bus.score_p1, bus.game_over);
        else pass_cnt++;
        ticks(1, 1'b0);
        chk_cnt++;
        if ({bus.state_dbg, bus.game_over} !== {ST_OVER, 1'b1})
            $display("FAIL game_over: got st %0d over %b want st 4 over 1", bus.state_dbg, bus.game_over);
        else pass_cnt++;
        pulse_serve();
        tick(1'b0, 2'b10);
        @(negedge clk);
        chk_cnt++;
        if ({bus.state_dbg, bus.ball_velocity, bus.score_p1, bus.ball_location} !==
            {ST_OVER, 32'd0, 4'd11, 11'd395, 11'd100})
            $display("FAIL over_ignores: got st %0d vel %h sc1 %0d loc %h want st 4 vel 0 sc1 11 loc held",
                     bus.state_dbg, bus.ball_velocity, bus.score_p1, bus.ball_location);
        else pass_cnt++;
        pulse_restart();
        chk_cnt++;
        if ({bus.state_dbg, bus.score_p0, bus.score_p1, bus.game_over, bus.server} !==
            {ST_IDLE, 4'd0, 4'd0, 1'b0, 1'b0})
            $display("FAIL restart_after_over: got st %0d sc %0d/%0d over %b srv %b want all 0",
                     bus.state_dbg, bus.score_p0, bus.score_p1, bus.game_over, bus.server);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_serve_fly();
        test_paddle_hit();
        test_edge_point();
        test_edge_and_collide();
        test_async_reset();
        test_game_over();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
